// File: rtl/dcore_dbg_pack.sv
// dcore_dbg_pack: shared region encodings, control bits and address field widths for the debug register file.
package dcore_dbg_pack;
  typedef enum logic [1:0] {
    REG_SHADOW = 2'd0,
    REG_ACTIVE = 2'd1,
    REG_STAT   = 2'd2,
    REG_CTRL   = 2'd3
  } region_e;
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_SNAP   = 1;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int idx_w(input int ncfg, input int nstat);
    return ch_w(ncfg > nstat ? ncfg : nstat);
  endfunction
endpackage

// File: rtl/dcore_dbg_cfg_bank.sv
// dcore_dbg_cfg_bank: one channel's shadow config words plus the active copy loaded from them on commit.
module dcore_dbg_cfg_bank #(
  parameter int Ncfg = 4,
  parameter int Wcfg = 16,
  parameter int Wix = 2,
  parameter logic [Wcfg-1:0] CFG_RST = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [Wix-1:0]       idx,
  input  logic [Wcfg-1:0]      wdata,
  input  logic                 load,
  output logic [Ncfg*Wcfg-1:0] shadow,
  output logic [Ncfg*Wcfg-1:0] active
);
  logic [Wcfg-1:0] sh [Ncfg];
  logic [Wcfg-1:0] ac [Ncfg];
  always_ff @(posedge clk) begin
    for (int i = 0; i < Ncfg; i++) begin
      if (rst) begin
        sh[i] <= CFG_RST;
        ac[i] <= CFG_RST;
      end else begin
        if (we && idx == Wix'(i)) sh[i] <= wdata;
        if (load) ac[i] <= sh[i];
      end
    end
  end
  for (genvar i = 0; i < Ncfg; i++) begin : g_flat
    assign shadow[i*Wcfg +: Wcfg] = sh[i];
    assign active[i*Wcfg +: Wcfg] = ac[i];
  end
endmodule

// File: rtl/dcore_debug_regfile.sv
// dcore_debug_regfile: JTAG-side debug register file with double-buffered config and coherent status snapshots.
module dcore_debug_regfile
  import dcore_dbg_pack::*;
#(
  parameter int Nch = 16,
  parameter int Ncfg = 4,
  parameter int Nstat = 2,
  parameter int Wcfg = 16,
  parameter int Wstat = 24,
  parameter int Wdata = 32,
  parameter int CFG_RST = 0,
  parameter int Waddr = 2 + ch_w(Nch) + idx_w(Ncfg, Nstat)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic                       req_bcast,
  input  logic [Waddr-1:0]           req_addr,
  input  logic [Wdata-1:0]           req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [Wdata-1:0]           rsp_rdata,
  output logic                       rsp_err,
  input  logic                       commit_ext,
  input  logic                       snap_ext,
  output logic [Nch*Ncfg*Wcfg-1:0]   cfg_active,
  output logic                       cfg_update,
  input  logic [Nch*Nstat*Wstat-1:0] stat_in,
  output logic                       snap_done
);
  localparam int Wch = ch_w(Nch);
  localparam int Wix = idx_w(Ncfg, Nstat);
  region_e         region;
  logic [Wch-1:0]  ch;
  logic [Wix-1:0]  idx;
  logic            acc, err, cfg_wr, ctrl_wr;
  logic            commit_pending, snap_pending, commit_trig, snap_trig;
  logic [Nch-1:0]  we_c;
  logic [Ncfg*Wcfg-1:0] sh_flat [Nch];
  logic [Ncfg*Wcfg-1:0] ac_flat [Nch];
  logic [Wstat-1:0] snap [Nch][Nstat];
  logic [Wcfg-1:0]  sh_word, ac_word;
  logic [Wstat-1:0] st_word;
  logic [Wdata-1:0] st_ext, rd;
  assign region = region_e'(req_addr[Waddr-1 -: 2]);
  assign ch = req_addr[Wix +: Wch];
  assign idx = req_addr[Wix-1:0];
  assign req_ready = !rsp_valid || rsp_ready;
  assign acc = req_valid && req_ready;
  always_comb begin
    err = (!req_bcast && int'(ch) >= Nch)
       || (region == REG_STAT ? int'(idx) >= Nstat
         : region == REG_CTRL ? idx != '0 : int'(idx) >= Ncfg)
       || (req_we && (region == REG_ACTIVE || region == REG_STAT))
       || (req_bcast && !(req_we && region == REG_SHADOW));
    cfg_wr = acc && req_we && !err && region == REG_SHADOW;
    ctrl_wr = acc && req_we && !err && region == REG_CTRL;
    commit_trig = commit_ext || (ctrl_wr && req_wdata[CTRL_COMMIT]);
    snap_trig = snap_ext || (ctrl_wr && req_wdata[CTRL_SNAP]);
  end
  for (genvar c = 0; c < Nch; c++) begin : g_bank
    assign we_c[c] = cfg_wr && (req_bcast || ch == Wch'(c));
    dcore_dbg_cfg_bank #(
      .Ncfg(Ncfg), .Wcfg(Wcfg), .Wix(Wix), .CFG_RST(Wcfg'(CFG_RST))
    ) u_bank (
      .clk(clk), .rst(rst), .we(we_c[c]), .idx(idx), .wdata(req_wdata[Wcfg-1:0]),
      .load(commit_pending), .shadow(sh_flat[c]), .active(ac_flat[c])
    );
    assign cfg_active[c*Ncfg*Wcfg +: Ncfg*Wcfg] = ac_flat[c];
  end
  // Out-of-range selects only occur on error paths, where the response data is forced to zero.
  always_comb begin
    sh_word = sh_flat[ch][idx*Wcfg +: Wcfg];
    ac_word = ac_flat[ch][idx*Wcfg +: Wcfg];
    st_word = snap[ch][idx];
  end
  assign st_ext = Wdata'($signed(st_word));
  assign rd = region == REG_SHADOW ? Wdata'(sh_word)
            : region == REG_ACTIVE ? Wdata'(ac_word)
            : region == REG_STAT ? st_ext
            : Wdata'({snap_pending, commit_pending});
  // A trigger arriving while already pending is absorbed into the same load.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_pending <= 1'b0;
      snap_pending <= 1'b0;
      cfg_update <= 1'b0;
      snap_done <= 1'b0;
    end else begin
      commit_pending <= commit_pending ? 1'b0 : commit_trig;
      snap_pending <= snap_pending ? 1'b0 : snap_trig;
      cfg_update <= commit_pending;
      snap_done <= snap_pending;
    end
  end
  always_ff @(posedge clk) begin
    for (int c = 0; c < Nch; c++) begin
      for (int i = 0; i < Nstat; i++) begin
        if (rst) snap[c][i] <= '0;
        else if (snap_pending) snap[c][i] <= stat_in[(c*Nstat+i)*Wstat +: Wstat];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
    end else if (acc) begin
      rsp_valid <= 1'b1;
      rsp_err <= err;
      rsp_rdata <= (err || req_we) ? '0 : rd;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dcore_debug_regfile.sv
// tb_dcore_debug_regfile: directed self-checking bench for the debug register file, 6 channels so ch=Nch is addressable.
module tb_dcore_debug_regfile;
  localparam int NCH = 6, NCFG = 4, NSTAT = 2, WCFG = 16, WSTAT = 24, WDATA = 32, WADDR = 7;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_we = 0, req_bcast = 0;
  logic [WADDR-1:0] req_addr = '0;
  logic [WDATA-1:0] req_wdata = '0, rsp_rdata;
  logic rsp_valid, rsp_ready = 1, rsp_err;
  logic commit_ext = 0, snap_ext = 0, cfg_update, snap_done;
  logic [NCH*NCFG*WCFG-1:0] cfg_active;
  logic [NCH*NSTAT*WSTAT-1:0] stat_in = '0;
  int total = 0, bad = 0;
  logic [31:0] rd;
  logic er, ok;

  dcore_debug_regfile #(
    .Nch(NCH), .Ncfg(NCFG), .Nstat(NSTAT), .Wcfg(WCFG), .Wstat(WSTAT),
    .Wdata(WDATA), .CFG_RST(0), .Waddr(WADDR)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bcast(req_bcast), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .commit_ext(commit_ext),
    .snap_ext(snap_ext), .cfg_active(cfg_active), .cfg_update(cfg_update), .stat_in(stat_in),
    .snap_done(snap_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] act(input int c, input int i);
    return cfg_active[(c*NCFG+i)*WCFG +: WCFG];
  endfunction

  task automatic drive(input logic we, input logic bc, input logic [1:0] rg, input int c, input int i, input logic [31:0] wd);
    req_valid = 1; req_we = we; req_bcast = bc; req_addr = {rg, 3'(c), 2'(i)}; req_wdata = wd;
  endtask

  task automatic idle();
    req_valid = 0; req_we = 0; req_bcast = 0;
  endtask

  task automatic do_req(input logic we, input logic bc, input logic [1:0] rg, input int c, input int i,
                        input logic [31:0] wd, output logic [31:0] d, output logic e, output logic v);
    @(negedge clk);
    drive(we, bc, rg, c, i, wd);
    v = req_ready;
    @(posedge clk); #1;
    idle();
    v = v && rsp_valid;
    d = rsp_rdata;
    e = rsp_err;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(0, 0, 2'd1, 3, 2, 0);
    repeat (3) @(posedge clk);
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if ({cfg_update, snap_done, rsp_err} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {cfg_update, snap_done, rsp_err}); end
    total++; if (cfg_active !== '0) begin bad++; $display("FAIL reset_cfg_active got=%h exp=0", cfg_active); end
    @(negedge clk);
    rst = 0; idle();
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_dropped_req got=%b exp=0", rsp_valid); end
    do_req(0, 0, 2'd1, 3, 2, 0, rd, er, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL reset_read_latency got=%b exp=1", ok); end
    total++; if ({er, rd} !== 33'h0) begin bad++; $display("FAIL reset_read_active got err=%b data=%h exp err=0 data=0", er, rd); end
  endtask

  task automatic test_commit();
    do_req(1, 0, 2'd0, 5, 1, 32'h1234, rd, er, ok);
    total++; if ({ok, er, rd} !== {1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL shadow_write got ok=%b err=%b data=%h exp 1 0 0", ok, er, rd); end
    do_req(0, 0, 2'd0, 5, 1, 0, rd, er, ok);
    total++; if (rd !== 32'h1234) begin bad++; $display("FAIL shadow_readback got=%h exp=00001234", rd); end
    do_req(0, 0, 2'd1, 5, 1, 0, rd, er, ok);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL active_before_commit got=%h exp=0", rd); end
    do_req(1, 0, 2'd3, 0, 0, 32'h1, rd, er, ok);
    total++; if ({cfg_update, act(5, 1)} !== {1'b0, 16'h0}) begin bad++; $display("FAIL commit_trigger_cycle got upd=%b act=%h exp 0 0000", cfg_update, act(5, 1)); end
    @(posedge clk); #1;
    total++; if ({cfg_update, act(5, 1)} !== {1'b1, 16'h1234}) begin bad++; $display("FAIL commit_load got upd=%b act=%h exp 1 1234", cfg_update, act(5, 1)); end
    @(posedge clk); #1;
    total++; if (cfg_update !== 1'b0) begin bad++; $display("FAIL cfg_update_width got=%b exp=0", cfg_update); end
    do_req(0, 0, 2'd1, 5, 1, 0, rd, er, ok);
    total++; if (rd !== 32'h1234) begin bad++; $display("FAIL active_after_commit got=%h exp=00001234", rd); end
  endtask

  task automatic test_bcast();
    do_req(1, 1, 2'd0, 0, 0, 32'hFFFF_BEEF, rd, er, ok);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL bcast_write_err got=%b exp=0", er); end
    @(negedge clk); commit_ext = 1;
    @(posedge clk); #1;
    total++; if (cfg_update !== 1'b0) begin bad++; $display("FAIL bcast_pending got=%b exp=0", cfg_update); end
    @(posedge clk); #1;
    total++; if (cfg_update !== 1'b1) begin bad++; $display("FAIL bcast_commit_pulse got=%b exp=1", cfg_update); end
    @(negedge clk); commit_ext = 0;
    @(posedge clk); #1;
    total++; if (cfg_update !== 1'b0) begin bad++; $display("FAIL merged_commit got=%b exp=0", cfg_update); end
    for (int c = 0; c < NCH; c++) begin
      total++; if (act(c, 0) !== 16'hBEEF) begin bad++; $display("FAIL bcast_ch%0d got=%h exp=beef", c, act(c, 0)); end
    end
    total++; if ({act(5, 1), act(0, 1), act(2, 3)} !== {16'h1234, 16'h0, 16'h0}) begin bad++; $display("FAIL bcast_other_idx got=%h %h %h exp 1234 0000 0000", act(5, 1), act(0, 1), act(2, 3)); end
  endtask

  task automatic test_snap();
    stat_in[(2*NSTAT+0)*WSTAT +: WSTAT] = 24'hFFFFFB;
    stat_in[(2*NSTAT+1)*WSTAT +: WSTAT] = 24'h000123;
    @(negedge clk); snap_ext = 1;
    @(negedge clk); snap_ext = 0;
    @(posedge clk); #1;
    total++; if (snap_done !== 1'b1) begin bad++; $display("FAIL snap_done got=%b exp=1", snap_done); end
    stat_in = {(NCH*NSTAT){24'h00_0077}};
    @(posedge clk); #1;
    total++; if (snap_done !== 1'b0) begin bad++; $display("FAIL snap_done_width got=%b exp=0", snap_done); end
    do_req(0, 0, 2'd2, 2, 0, 0, rd, er, ok);
    total++; if ({er, rd} !== {1'b0, 32'hFFFF_FFFB}) begin bad++; $display("FAIL snap_sign_ext got err=%b data=%h exp 0 fffffffb", er, rd); end
    do_req(0, 0, 2'd2, 2, 1, 0, rd, er, ok);
    total++; if (rd !== 32'h0000_0123) begin bad++; $display("FAIL snap_positive got=%h exp=00000123", rd); end
    do_req(0, 0, 2'd2, 3, 0, 0, rd, er, ok);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL snap_other_ch got=%h exp=0", rd); end
  endtask

  task automatic test_errors();
    do_req(1, 0, 2'd1, 5, 1, 32'hAAAA, rd, er, ok);
    total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL err_write_active got err=%b data=%h exp 1 0", er, rd); end
    do_req(1, 0, 2'd0, NCH, 0, 32'hDEAD, rd, er, ok);
    total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL err_ch_range got err=%b data=%h exp 1 0", er, rd); end
    do_req(0, 0, 2'd3, 0, 1, 0, rd, er, ok);
    total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL err_ctrl_idx got err=%b data=%h exp 1 0", er, rd); end
    do_req(0, 0, 2'd2, 2, 2, 0, rd, er, ok);
    total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL err_stat_idx got err=%b data=%h exp 1 0", er, rd); end
    do_req(0, 1, 2'd0, 5, 1, 0, rd, er, ok);
    total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL err_bcast_read got err=%b data=%h exp 1 0", er, rd); end
    do_req(1, 0, 2'd3, 0, 1, 32'h3, rd, er, ok);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_ctrl_write got=%b exp=1", er); end
    @(posedge clk); #1;
    total++; if ({cfg_update, snap_done} !== 2'b00) begin bad++; $display("FAIL err_no_trigger got=%b exp=00", {cfg_update, snap_done}); end
    do_req(0, 0, 2'd1, 5, 1, 0, rd, er, ok);
    total++; if (rd !== 32'h1234) begin bad++; $display("FAIL err_active_kept got=%h exp=00001234", rd); end
    do_req(0, 0, 2'd0, 5, 0, 0, rd, er, ok);
    total++; if (rd !== 32'hBEEF) begin bad++; $display("FAIL err_shadow_kept got=%h exp=0000beef", rd); end
    do_req(0, 0, 2'd3, 0, 0, 0, rd, er, ok);
    total++; if ({er, rd} !== {1'b0, 32'h0}) begin bad++; $display("FAIL ctrl_status got err=%b data=%h exp 0 0", er, rd); end
  endtask

  task automatic test_backpressure();
    do_req(0, 0, 2'd1, 5, 1, 0, rd, er, ok);
    rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if ({req_ready, rsp_valid, rsp_rdata} !== {1'b0, 1'b1, 32'h1234}) begin bad++; $display("FAIL stall_%0d got rdy=%b vld=%b data=%h exp 0 1 00001234", k, req_ready, rsp_valid, rsp_rdata); end
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    total++; if ({req_ready, rsp_valid} !== 2'b11 && {req_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL stall_release got=%b exp=1x", {req_ready, rsp_valid}); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_same_cycle_commit();
    do_req(1, 0, 2'd0, 5, 1, 32'h1111, rd, er, ok);
    @(negedge clk); commit_ext = 1;
    @(negedge clk); commit_ext = 0; drive(1, 0, 2'd0, 5, 1, 32'h5678);
    @(posedge clk); #1; idle();
    total++; if ({cfg_update, act(5, 1)} !== {1'b1, 16'h1111}) begin bad++; $display("FAIL race_commit got upd=%b act=%h exp 1 1111", cfg_update, act(5, 1)); end
    @(negedge clk); commit_ext = 1;
    @(negedge clk); commit_ext = 0;
    @(posedge clk); #1;
    total++; if (act(5, 1) !== 16'h5678) begin bad++; $display("FAIL race_second_commit got=%h exp=5678", act(5, 1)); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 2'd0, k, 3, 32'h100 + k);
      @(posedge clk); #1;
      total++; if ({rsp_valid, rsp_err, req_ready} !== 3'b101) begin bad++; $display("FAIL b2b_write_%0d got=%b exp=101", k, {rsp_valid, rsp_err, req_ready}); end
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 2'd0, k, 3, 0);
      @(posedge clk); #1;
      total++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h100 + k}) begin bad++; $display("FAIL b2b_read_%0d got vld=%b data=%h exp 1 %h", k, rsp_valid, rsp_rdata, 32'h100 + k); end
    end
    idle();
    do_req(1, 0, 2'd3, 0, 0, 32'h3, rd, er, ok);
    @(posedge clk); #1;
    total++; if ({cfg_update, snap_done, act(1, 3)} !== {2'b11, 16'h0101}) begin bad++; $display("FAIL commit_and_snap got upd=%b snp=%b act=%h exp 1 1 0101", cfg_update, snap_done, act(1, 3)); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_bcast();
    test_snap();
    test_errors();
    test_backpressure();
    test_same_cycle_commit();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
